mole_hit_scorer: RTL and testbench
==================================

Name: mole_hit_scorer

Overview:
- Consumer side of the game-control FSM's mole_clk / game_in_progress / rst interface. The FSM decides *when* a mole is up; this block decides *which* mole is up.
- Picks a pseudo-random mole position on each mole-up edge and drives the one-hot mole LEDs.
- Detects player whacks from the hit buttons and keeps saturating hit and miss counts for display.
- Sits between the game FSM and the LED/7-segment display logic.

Parameters:
- NUM_MOLES, 8: number of moles, buttons and LEDs (2..16).
- SCORE_W, 8: width of the hit and miss counters.
- LFSR_SEED, 16'hACE1: reset value of the 16-bit LFSR (must be non-zero).
- WRONG_PENALTY, 1: if 1, a wrong-button hit decrements score (floor 0); if 0, no penalty.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- game_rst  in  1  synchronous one-cycle clear pulse from the game FSM (its rst output).
- game_in_progress  in  1  high while a game runs.
- mole_clk  in  1  high = mole-up window, low = mole-down window; registered upstream, glitch-free.
- hit_buttons  in  NUM_MOLES  asynchronous active-high player buttons.
- mole_leds  out  NUM_MOLES  one-hot lit mole; all zero when no mole is up.
- score  out  SCORE_W  hit count.
- misses  out  SCORE_W  count of mole windows that expired unhit.
- hit_pulse  out  1  one-cycle pulse on a correct whack.
- wrong_pulse  out  1  one-cycle pulse on a wrong-button press during UP.
- miss_pulse  out  1  one-cycle pulse when an UP window closes unhit.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; all outputs 0.
  - LFSR = LFSR_SEED; synchronizers and edge registers cleared.
- Input conditioning:
  - Each hit_buttons bit passes through a 2-flop synchronizer plus one delay flop.
  - press = sync2 & ~sync3.
  - A button first sampled high at edge k is acted on at edge k+2.
  - mole_clk is used directly, with one delay flop: mole_rise = mole_clk & ~q; mole_fall = ~mole_clk & q.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every clk; unaffected by game_rst and game state.
- Position selection at mole_rise:
  - cand = lfsr % NUM_MOLES.
  - If cand equals the previous position, pos = (cand+1) % NUM_MOLES.
  - pos is latched; the previous-position register updates.
- States:
  - IDLE: mole_leds = 0. On rising edge of game_in_progress, clear score and misses, then go to WAIT_UP.
  - WAIT_UP: mole_leds = 0. On mole_rise, latch pos and go to UP.
  - UP: mole_leds = 1<<pos.
    - Any press on a bit other than pos: wrong_pulse; apply penalty if WRONG_PENALTY = 1; stay in UP.
    - Otherwise, press on bit pos: score+1, hit_pulse, go to WHACKED.
    - mole_fall with no correct hit: misses+1, miss_pulse, go to WAIT_UP.
  - WHACKED: mole_leds = 0. On mole_fall, go to WAIT_UP. Presses are ignored.
- Priority (highest first): game_rst > game_in_progress low > events.
  - game_rst in any state: score = misses = 0, no pulses, state = IDLE.
  - game_in_progress low in any non-IDLE state: go to IDLE; score and misses are held for display; no miss is counted for an open UP window.
- Simultaneous events in UP:
  - Correct and wrong presses in the same cycle count as a wrong press only (anti-mash); no score increment.
  - A correct press and mole_fall in the same cycle count as a hit (hit wins).
  - mole_rise while already in UP (should not occur) is ignored.
- Arithmetic:
  - score and misses saturate at 2^SCORE_W-1.
  - The penalty decrement saturates at 0.
- Pulses are registered, exactly one cycle wide, and mutually exclusive.

Test Plan:
1. Reset release, game_in_progress 0→1, mole_clk rises → mole_leds is one-hot within 1 cycle of mole_rise; score = 0, misses = 0.
2. In UP with pos = p, assert hit_buttons[p] for 5 cycles → at edge k+2: hit_pulse for one cycle, score = 1, LEDs 0; a second press before mole_fall leaves score at 1.
3. In UP, no press until mole_clk falls → miss_pulse once, misses = 1, score unchanged. Over 20 windows the position never repeats back-to-back.
4. WRONG_PENALTY = 1, score = 3:
   - wrong button → wrong_pulse, score = 2.
   - With score = 0, wrong button → score stays 0.
   - Correct and wrong pressed in the same cycle → wrong only, score unchanged.
5. Preload score = 255 (SCORE_W = 8), then correct hit → score stays 255 and hit_pulse still fires.
6. Mid-UP, game_rst pulse → state IDLE, LEDs 0, score = misses = 0. Separately, game_in_progress falling mid-UP → IDLE with score held and misses not incremented. rst_n asserted mid-game → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mole_hit_scorer.sv
// Whack-a-mole scorer: picks a pseudo-random mole on each mole-up edge, lights it,
// and turns synchronized button presses into saturating hit/miss counts and event pulses.
module mole_hit_scorer #(
    parameter int          NUM_MOLES     = 8,
    parameter int          SCORE_W       = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          WRONG_PENALTY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 game_rst,
    input  logic                 game_in_progress,
    input  logic                 mole_clk,
    input  logic [NUM_MOLES-1:0] hit_buttons,
    output logic [NUM_MOLES-1:0] mole_leds,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   misses,
    output logic                 hit_pulse,
    output logic                 wrong_pulse,
    output logic                 miss_pulse
);

    localparam int                   POS_W     = $clog2(NUM_MOLES);
    localparam logic [SCORE_W-1:0]   SCORE_MAX = '1;
    localparam logic [NUM_MOLES-1:0] ONE_HOT0  = NUM_MOLES'(1);
    localparam logic [POS_W-1:0]     LAST_POS  = POS_W'(NUM_MOLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_UP, UP, WHACKED} state_t;

    state_t               state;
    logic [15:0]          lfsr;
    logic [NUM_MOLES-1:0] btn_s1, btn_s2, btn_s3;
    logic                 mole_q, gip_q;
    logic [POS_W-1:0]     pos;
    logic [POS_W-1:0]     cand, next_pos;
    logic [NUM_MOLES-1:0] press, pos_mask;
    logic                 mole_rise, mole_fall, game_start;
    logic                 hit_press, wrong_press;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
    endfunction

    // NOTE: every register below is assigned with <= so all flops sample pre-edge values together.
    // NOTE: btn_s1/btn_s2 form the metastability synchronizer; only btn_s2/btn_s3 feed logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr   <= LFSR_SEED;
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_s3 <= '0;
            mole_q <= 1'b0;
            gip_q  <= 1'b0;
        end else begin
            lfsr   <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            btn_s1 <= hit_buttons;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
            mole_q <= mole_clk;
            gip_q  <= game_in_progress;
        end
    end

    always_comb begin
        press       = btn_s2 & ~btn_s3;
        mole_rise   = mole_clk & ~mole_q;
        mole_fall   = ~mole_clk & mole_q;
        game_start  = game_in_progress & ~gip_q;
        pos_mask    = ONE_HOT0 << pos;
        hit_press   = |(press & pos_mask);
        wrong_press = |(press & ~pos_mask);
        cand        = POS_W'(lfsr % 16'(NUM_MOLES));
        next_pos    = cand;
        if (cand == pos) begin
            next_pos = (cand == LAST_POS) ? '0 : cand + POS_W'(1);
        end
    end

    // pos doubles as the previous-position register: it only changes when a new mole is latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pos         <= '0;
            mole_leds   <= '0;
            score       <= '0;
            misses      <= '0;
            hit_pulse   <= 1'b0;
            wrong_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
        end else begin
            hit_pulse   <= 1'b0;
            wrong_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            if (game_rst) begin
                state     <= IDLE;
                mole_leds <= '0;
                score     <= '0;
                misses    <= '0;
            end else if (!game_in_progress && state != IDLE) begin
                state     <= IDLE;
                mole_leds <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (game_start) begin
                            score  <= '0;
                            misses <= '0;
                            state  <= WAIT_UP;
                        end
                    end
                    WAIT_UP: begin
                        if (mole_rise) begin
                            pos       <= next_pos;
                            mole_leds <= ONE_HOT0 << next_pos;
                            state     <= UP;
                        end
                    end
                    UP: begin
                        // A clean hit beats a closing window; a closing window beats a stray press,
                        // so the window is never lost and at most one pulse fires per cycle.
                        if (hit_press && !wrong_press) begin
                            hit_pulse <= 1'b1;
                            score     <= sat_inc(score);
                            mole_leds <= '0;
                            state     <= mole_fall ? WAIT_UP : WHACKED;
                        end else if (mole_fall) begin
                            miss_pulse <= 1'b1;
                            misses     <= sat_inc(misses);
                            mole_leds  <= '0;
                            state      <= WAIT_UP;
                        end else if (wrong_press) begin
                            wrong_pulse <= 1'b1;
                            if (WRONG_PENALTY != 0 && score != '0) begin
                                score <= score - SCORE_W'(1);
                            end
                        end
                    end
                    WHACKED: begin
                        if (mole_fall) begin
                            state <= WAIT_UP;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        mole_leds <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mole_hit_scorer.sv
// Directed bench for mole_hit_scorer: hand-sequenced game with an LFSR reference for the
// expected mole position and immediate assertions at each comparison.
module tb_mole_hit_scorer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         game_rst = 1'b0;
    logic         game_in_progress = 1'b0;
    logic         mole_clk = 1'b0;
    logic [N-1:0] hit_buttons = '0;
    logic [N-1:0] mole_leds;
    logic [7:0]   score, misses;
    logic         hit_pulse, wrong_pulse, miss_pulse;

    int checks = 0;
    int errors = 0;
    int exp_score = 0;
    int exp_misses = 0;
    int exp_pos = 0;
    int m_prev = 0;
    logic [15:0]  m_lfsr;
    logic [N-1:0] last_leds;

    mole_hit_scorer #(
        .NUM_MOLES(N), .SCORE_W(8), .LFSR_SEED(16'hACE1), .WRONG_PENALTY(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .game_rst(game_rst), .game_in_progress(game_in_progress),
        .mole_clk(mole_clk), .hit_buttons(hit_buttons), .mole_leds(mole_leds),
        .score(score), .misses(misses), .hit_pulse(hit_pulse),
        .wrong_pulse(wrong_pulse), .miss_pulse(miss_pulse)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR for x^16+x^14+x^13+x^11+1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic raise_mole(input string tag);
        int cand;
        cand     = int'(m_lfsr % 16'd8);
        exp_pos  = (cand == m_prev) ? (cand + 1) % N : cand;
        m_prev   = exp_pos;
        mole_clk = 1'b1;
        step();
        check(tag, 32'(mole_leds), 32'(1) << exp_pos);
    endtask

    task automatic do_hit(input string tag);
        hit_buttons = N'(1) << exp_pos;
        step();
        step();
        check({tag, "_early_pulse"}, 32'(hit_pulse), 0);
        check({tag, "_early_score"}, 32'(score), exp_score);
        step();
        exp_score = (exp_score == 255) ? 255 : exp_score + 1;
        check({tag, "_pulse"}, 32'(hit_pulse), 1);
        check({tag, "_score"}, 32'(score), exp_score);
        check({tag, "_leds"}, 32'(mole_leds), 0);
        hit_buttons = '0;
        step();
        check({tag, "_pulse_end"}, 32'(hit_pulse), 0);
    endtask

    task automatic close_after_hit(input string tag);
        mole_clk = 1'b0;
        step();
        check({tag, "_no_miss"}, 32'(miss_pulse), 0);
        check({tag, "_misses"}, 32'(misses), exp_misses);
    endtask

    task automatic miss_window(input string tag);
        step();
        step();
        mole_clk = 1'b0;
        step();
        exp_misses = (exp_misses == 255) ? 255 : exp_misses + 1;
        check({tag, "_pulse"}, 32'(miss_pulse), 1);
        check({tag, "_misses"}, 32'(misses), exp_misses);
        check({tag, "_score"}, 32'(score), exp_score);
        check({tag, "_leds"}, 32'(mole_leds), 0);
        step();
        check({tag, "_pulse_end"}, 32'(miss_pulse), 0);
    endtask

    task automatic press_wrong(input logic [N-1:0] mask, input string tag);
        hit_buttons = mask;
        step();
        step();
        step();
        if (exp_score > 0) exp_score--;
        check({tag, "_pulse"}, 32'(wrong_pulse), 1);
        check({tag, "_hit"}, 32'(hit_pulse), 0);
        check({tag, "_score"}, 32'(score), exp_score);
        check({tag, "_leds"}, 32'(mole_leds), 32'(1) << exp_pos);
        hit_buttons = '0;
        step();
        check({tag, "_pulse_end"}, 32'(wrong_pulse), 0);
        step();
        step();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step();
        step();
        check("rst_leds", 32'(mole_leds), 0);
        check("rst_score", 32'(score), 0);
        check("rst_misses", 32'(misses), 0);
        check("rst_pulses", {29'd0, hit_pulse, wrong_pulse, miss_pulse}, 0);
        rst_n = 1'b1;
        step();
        check("idle_leds", 32'(mole_leds), 0);

        // Start a game and take a first correct hit.
        game_in_progress = 1'b1;
        step();
        check("wait_leds", 32'(mole_leds), 0);
        raise_mole("w1_leds");
        last_leds = mole_leds;
        do_hit("hit1");
        step();
        step();
        hit_buttons = N'(1) << exp_pos;
        step();
        step();
        step();
        check("rehit_score", 32'(score), 1);
        check("rehit_pulse", 32'(hit_pulse), 0);
        check("rehit_wrong", 32'(wrong_pulse), 0);
        hit_buttons = '0;
        step();
        close_after_hit("hit1_close");

        // Twenty unhit windows; position must never repeat back-to-back.
        for (int w = 0; w < 20; w++) begin
            raise_mole("miss_leds");
            check("no_repeat", 32'(mole_leds != last_leds), 1);
            last_leds = mole_leds;
            miss_window("miss");
        end
        check("misses_20", 32'(misses), 20);

        // Correct press coinciding with window close counts as a hit.
        raise_mole("hf_leds");
        hit_buttons = N'(1) << exp_pos;
        step();
        step();
        mole_clk = 1'b0;
        step();
        exp_score++;
        check("hf_hit_pulse", 32'(hit_pulse), 1);
        check("hf_miss_pulse", 32'(miss_pulse), 0);
        check("hf_score", 32'(score), exp_score);
        check("hf_misses", 32'(misses), exp_misses);
        hit_buttons = '0;
        step();
        raise_mole("hit3_leds");
        do_hit("hit3");
        close_after_hit("hit3_close");
        check("score_3", 32'(score), 3);

        // Wrong-button penalty, floor at zero, and anti-mash.
        raise_mole("wr_leds");
        press_wrong(N'(1) << ((exp_pos + 1) % N), "wrong_a");
        check("score_2", 32'(score), 2);
        press_wrong(N'(1) << ((exp_pos + 2) % N), "wrong_b");
        press_wrong(N'(1) << ((exp_pos + 3) % N), "wrong_c");
        press_wrong(N'(1) << ((exp_pos + 4) % N), "wrong_floor");
        check("score_floor", 32'(score), 0);
        press_wrong((N'(1) << exp_pos) | (N'(1) << ((exp_pos + 5) % N)), "mash");
        miss_window("wr_close");

        // Drive score to saturation, then one more hit.
        for (int h = 0; h < 255; h++) begin
            raise_mole("sat_leds");
            do_hit("sat");
            close_after_hit("sat_close");
        end
        check("score_255", 32'(score), 255);
        raise_mole("top_leds");
        do_hit("top");
        check("score_held_255", 32'(score), 255);
        close_after_hit("top_close");

        // game_rst mid-window clears everything and returns to IDLE.
        raise_mole("grst_leds");
        game_rst = 1'b1;
        step();
        game_rst = 1'b0;
        exp_score = 0;
        exp_misses = 0;
        check("grst_leds_off", 32'(mole_leds), 0);
        check("grst_score", 32'(score), 0);
        check("grst_misses", 32'(misses), 0);
        check("grst_pulses", {29'd0, hit_pulse, wrong_pulse, miss_pulse}, 0);
        mole_clk = 1'b0;
        step();
        check("grst_no_miss", 32'(misses), 0);

        // Restart, score one hit and one miss, then abort the game mid-window.
        game_in_progress = 1'b0;
        step();
        game_in_progress = 1'b1;
        step();
        raise_mole("g2_leds");
        do_hit("g2_hit");
        close_after_hit("g2_close");
        raise_mole("g2m_leds");
        miss_window("g2_miss");
        raise_mole("abort_leds");
        game_in_progress = 1'b0;
        step();
        check("abort_leds_off", 32'(mole_leds), 0);
        check("abort_score", 32'(score), 1);
        check("abort_misses", 32'(misses), 1);
        check("abort_miss_pulse", 32'(miss_pulse), 0);
        mole_clk = 1'b0;
        step();
        check("abort_misses_held", 32'(misses), 1);
        check("abort_miss_pulse2", 32'(miss_pulse), 0);

        // New game clears counters; then asynchronous reset mid-window.
        game_in_progress = 1'b1;
        step();
        exp_score = 0;
        exp_misses = 0;
        check("g3_score_clr", 32'(score), 0);
        check("g3_misses_clr", 32'(misses), 0);
        raise_mole("g3_leds");
        do_hit("g3_hit");
        close_after_hit("g3_close");
        raise_mole("arst_leds");
        #2 rst_n = 1'b0;
        #1;
        check("arst_leds", 32'(mole_leds), 0);
        check("arst_score", 32'(score), 0);
        check("arst_misses", 32'(misses), 0);
        check("arst_pulses", {29'd0, hit_pulse, wrong_pulse, miss_pulse}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
